// File: rtl/tpg_multimode_if.sv
// Vector stream between the pattern generator and the CUT/ORA.
// The master drives the vector and its index. The slave returns ready.
interface tpg_multimode_if #(
  parameter int BITS = 4,
  parameter int CW   = 4
);
  logic            valid;
  logic            ready;
  logic [BITS-1:0] TEST_PATTERN;
  logic [CW-1:0]   pattern_idx;

  modport master (output valid, TEST_PATTERN, pattern_idx, input ready);
  modport slave  (input valid, TEST_PATTERN, pattern_idx, output ready);
endinterface

// File: rtl/tpg_multimode.sv
// LBIST pattern generator (LFSR/count/walk-1/walk-0). The first vector is valid 1 cycle after start.
// The vector and its index hold while valid && !ready. All outputs are registered.
module tpg_multimode #(
  parameter int              BITS         = 4,
  parameter logic [BITS-1:0] TAPS         = 4'b1001,
  parameter int              NUM_PATTERNS = 15,
  localparam int             CW           = $clog2(NUM_PATTERNS + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic [1:0]      mode_i,
  input  logic [BITS-1:0] seed_i,
  output logic            busy_o,
  output logic            end_o,
  tpg_multimode_if.master pat_if
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [1:0]      M_LFSR   = 2'd0;
  localparam logic [1:0]      M_COUNT  = 2'd1;
  localparam logic [BITS-1:0] ONE      = {{(BITS-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]   LAST_IDX = CW'(NUM_PATTERNS - 1);

  state_e          state_q, state_d;
  logic [1:0]      mode_q, mode_d;
  logic [BITS-1:0] tp_q, tp_d;
  logic [CW-1:0]   idx_q, idx_d;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;
  logic            end_q, end_d;

  function automatic logic [BITS-1:0] first_vec(input logic [1:0] m, input logic [BITS-1:0] s);
    logic [BITS-1:0] v;
    case (m)
      M_LFSR:  v = (s == '0) ? ONE : s;  // all-zero is the LFSR lock-up state
      M_COUNT: v = s;
      2'd2:    v = ONE;
      default: v = ~ONE;
    endcase
    return v;
  endfunction

  function automatic logic [BITS-1:0] next_vec(input logic [1:0] m, input logic [BITS-1:0] v);
    logic [BITS-1:0] n;
    case (m)
      M_LFSR:  n = {v[BITS-2:0], ^(v & TAPS)};
      M_COUNT: n = v + ONE;
      default: n = {v[BITS-2:0], v[BITS-1]};
    endcase
    return n;
  endfunction

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    tp_d    = tp_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          mode_d  = mode_i;
          tp_d    = first_vec(mode_i, seed_i);
          idx_d   = '0;
        end
      end
      RUN: begin
        // abort wins even over the final accept, so END is never raised
        if (abort_i) begin
          state_d = IDLE;
        end else if (valid_q && pat_if.ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            tp_d  = next_vec(mode_q, tp_q);
            idx_d = idx_q + CW'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    valid_d = (state_d == RUN);
    busy_d  = (state_d == RUN);
    end_d   = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      mode_q  <= '0;
      tp_q    <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      end_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      tp_q    <= tp_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      end_q   <= end_d;
    end
  end

  assign pat_if.valid        = valid_q;
  assign pat_if.TEST_PATTERN = tp_q;
  assign pat_if.pattern_idx  = idx_q;
  assign busy_o              = busy_q;
  assign end_o               = end_q;

endmodule

// File: tb/tb_tpg_multimode.sv
// Scoreboard bench for tpg_multimode: a 15-vector instance and a 4-vector instance share control inputs.
// Expected vectors are queued at stimulus time and popped on every accepted vector.
module tb_tpg_multimode;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start15 = 1'b0, start4 = 1'b0, abort = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [3:0] seed = 4'h0;
  logic       busy15, end15, busy4, end4;

  always #5 clk = ~clk;

  tpg_multimode_if #(.BITS(4), .CW(4)) if15();
  tpg_multimode_if #(.BITS(4), .CW(3)) if4();

  tpg_multimode dut15 (
    .clk(clk), .rst(rst), .start_i(start15), .abort_i(abort), .mode_i(mode), .seed_i(seed),
    .busy_o(busy15), .end_o(end15), .pat_if(if15)
  );

  tpg_multimode #(.NUM_PATTERNS(4)) dut4 (
    .clk(clk), .rst(rst), .start_i(start4), .abort_i(abort), .mode_i(mode), .seed_i(seed),
    .busy_o(busy4), .end_o(end4), .pat_if(if4)
  );

  typedef struct packed {
    logic [3:0] tp;
    logic [3:0] idx;
    logic       last;
  } exp_t;

  exp_t q15[$];
  exp_t q4[$];
  int   n_chk = 0;
  int   n_pass = 0;
  logic pend15 = 1'b0, pend4 = 1'b0;
  logic stall15 = 1'b0;
  logic [3:0] htp, hidx;

  logic [3:0] lfsr_tab [15] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hD, 4'hA, 4'h5,
                                4'hB, 4'h6, 4'hC, 4'h9, 4'h2, 4'h4, 4'h8};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (pend15 || end15) chk("end15", end15, pend15);
    pend15 = 1'b0;
    if (stall15 && if15.valid) begin
      chk("hold_tp", if15.TEST_PATTERN, htp);
      chk("hold_idx", if15.pattern_idx, hidx);
    end
    stall15 = if15.valid && !if15.ready && !abort;
    htp     = if15.TEST_PATTERN;
    hidx    = if15.pattern_idx;
    if (if15.valid && if15.ready && !abort) begin
      if (q15.size() == 0) chk("unexpected15", q15.size(), 1);
      else begin
        e = q15.pop_front();
        chk("tp15", if15.TEST_PATTERN, e.tp);
        chk("idx15", if15.pattern_idx, e.idx);
        pend15 = e.last;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (pend4 || end4) chk("end4", end4, pend4);
    pend4 = 1'b0;
    if (if4.valid && if4.ready && !abort) begin
      if (q4.size() == 0) chk("unexpected4", q4.size(), 1);
      else begin
        e = q4.pop_front();
        chk("tp4", if4.TEST_PATTERN, e.tp);
        chk("idx4", if4.pattern_idx, e.idx);
        pend4 = e.last;
      end
    end
  end

  task automatic push15(input logic [3:0] tp, input int idx, input int n);
    exp_t e;
    e.tp = tp; e.idx = 4'(idx); e.last = (idx == n - 1);
    q15.push_back(e);
  endtask

  task automatic push4(input logic [3:0] tp, input int idx);
    exp_t e;
    e.tp = tp; e.idx = 4'(idx); e.last = (idx == 3);
    q4.push_back(e);
  endtask

  task automatic pulse15();
    @(posedge clk); #1 start15 = 1'b1;
    @(posedge clk); #1 start15 = 1'b0;
  endtask

  task automatic pulse4();
    @(posedge clk); #1 start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
  endtask

  // bp=1 drives ready with the repeating pattern 0,0,1,1
  task automatic drain15(input int budget, input bit bp);
    int n = 0;
    while ((q15.size() != 0 || busy15) && n < budget) begin
      if (bp) if15.ready = (n % 4) >= 2;
      @(posedge clk); #1;
      n++;
    end
    chk("drain15_timeout", n < budget, 1);
    chk("drain15_left", q15.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic drain4(input int budget);
    int n = 0;
    while ((q4.size() != 0 || busy4) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain4_timeout", n < budget, 1);
    chk("drain4_left", q4.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int ecnt;
    bit hit;
    if15.ready = 1'b1;
    if4.ready  = 1'b1;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", if15.valid, 0);
    chk("rst_tp", if15.TEST_PATTERN, 0);
    chk("rst_idx", if15.pattern_idx, 0);
    chk("rst_busy", busy15, 0);
    chk("rst_end", end15, 0);
    chk("rst_valid4", if4.valid, 0);
    rst = 1'b1;

    // LFSR from seed 1 with a stray start and mode/seed change mid-run
    mode = 2'd0; seed = 4'h1;
    for (int i = 0; i < 15; i++) push15(lfsr_tab[i], i, 15);
    pulse15();
    chk("lat_valid", if15.valid, 1);
    chk("lat_busy", busy15, 1);
    repeat (3) @(posedge clk);
    #1 start15 = 1'b1; mode = 2'd2; seed = 4'h7;
    @(posedge clk);
    #1 start15 = 1'b0;
    drain15(100, 1'b0);
    chk("idle_busy", busy15, 0);
    chk("idle_valid", if15.valid, 0);

    // LFSR zero seed is replaced by 1
    mode = 2'd0; seed = 4'h0;
    for (int i = 0; i < 15; i++) push15(lfsr_tab[i], i, 15);
    pulse15();
    chk("zs_first", if15.TEST_PATTERN, 4'h1);
    drain15(100, 1'b0);

    // walking-one under backpressure
    mode = 2'd2;
    if15.ready = 1'b0;
    for (int i = 0; i < 15; i++) push15(4'(1 << (i % 4)), i, 15);
    pulse15();
    drain15(300, 1'b1);
    if15.ready = 1'b1;

    // asynchronous reset in the middle of a count run
    mode = 2'd1; seed = 4'h3;
    for (int i = 0; i < 15; i++) push15(4'(4'h3 + i), i, 15);
    pulse15();
    repeat (4) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", if15.valid, 0);
    chk("arst_tp", if15.TEST_PATTERN, 0);
    chk("arst_idx", if15.pattern_idx, 0);
    chk("arst_busy", busy15, 0);
    chk("arst_end", end15, 0);
    q15.delete();
    pend15 = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("arst_idle_busy", busy15, 0);
    chk("arst_idle_valid", if15.valid, 0);

    // count wrap on the 4-vector instance
    mode = 2'd1; seed = 4'hE;
    for (int i = 0; i < 4; i++) push4(4'(4'hE + i), i);
    pulse4();
    drain4(50);

    // walking-zero on the 4-vector instance
    mode = 2'd3;
    for (int i = 0; i < 4; i++) push4(~4'(1 << i), i);
    pulse4();
    drain4(50);

    // abort coinciding with the final accept
    mode = 2'd1; seed = 4'h0;
    for (int i = 0; i < 3; i++) push4(4'(i), i);
    pulse4();
    hit = 1'b0;
    for (int n = 0; n < 20 && !hit; n++) begin
      if (if4.valid && if4.pattern_idx == 3'd3) begin
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        hit = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
    end
    chk("abort_reached", hit, 1);
    chk("abort_busy", busy4, 0);
    chk("abort_valid", if4.valid, 0);
    chk("abort_left", q4.size(), 0);
    ecnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (end4) ecnt++;
    end
    chk("abort_no_end", ecnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
